// File: rtl/memory_if.sv
// Bus between the operand buffer and whatever loads it and consumes its lanes.
// The master side writes the matrix and drives the sequencer; the slave side is the buffer.
interface memory_if #(parameter int DW = 16);
  logic                 en_data;
  logic                 A_or_B;
  logic                 start_compute;
  logic                 stop;
  logic signed [DW-1:0] data_in;
  logic [5:0]           addr;
  logic [4:0]           instruction;
  logic signed [DW-1:0] data_o_0;
  logic signed [DW-1:0] data_o_1;
  logic signed [DW-1:0] data_o_2;
  logic signed [DW-1:0] data_o_3;
  logic                 mem_done;
  logic                 release_output;
  logic                 clear;
  logic [4:0]           cnt;
  logic [3:0]           current_iteration_debug;

  modport master (
    output en_data, A_or_B, start_compute, stop, data_in, addr, instruction,
    input  data_o_0, data_o_1, data_o_2, data_o_3, mem_done, release_output,
           clear, cnt, current_iteration_debug
  );

  modport slave (
    input  en_data, A_or_B, start_compute, stop, data_in, addr, instruction,
    output data_o_0, data_o_1, data_o_2, data_o_3, mem_done, release_output,
           clear, cnt, current_iteration_debug
  );
endinterface

// File: rtl/memory.sv
// Operand buffer for the 4x4 systolic array: stores an NxN matrix and streams it out
// as skewed 4x4 tiles (rows for operand A, columns for operand B), sequencing all tile iterations.
module memory #(
  parameter int DW          = 16,
  parameter int DEPTH       = 64,
  parameter int TILE_CYCLES = 12
) (
  input logic     clk,
  input logic     rst,
  memory_if.slave bus
);

  logic signed [DW-1:0] mem_q  [DEPTH];
  logic signed [DW-1:0] lane_q [4];
  logic signed [DW-1:0] lane_d [4];
  logic [4:0]           tileCnt_q;
  logic [3:0]           iter_q;
  logic                 done_q;
  logic                 clear_q;

  logic       dimIs4, running, tileEnd, lastIter, lastKk, releaseNow;
  logic       iBit, jBit, kkBit;
  logic [5:0] dimN, base;

  // For N=8 the iteration index is {i, j, kk}, one bit each; for N=4 all tile indices are zero.
  assign dimIs4 = (bus.instruction == 5'd4);
  assign dimN   = dimIs4 ? 6'd4 : 6'd8;
  assign iBit   = !dimIs4 && iter_q[2];
  assign jBit   = !dimIs4 && iter_q[1];
  assign kkBit  = !dimIs4 && iter_q[0];
  assign base   = bus.A_or_B ? {kkBit, 2'b00, jBit, 2'b00} : {iBit, 2'b00, kkBit, 2'b00};

  assign running    = bus.start_compute && !bus.stop && !done_q;
  assign tileEnd    = (tileCnt_q == 5'(TILE_CYCLES - 1));
  assign lastIter   = dimIs4 ? (iter_q == 4'd0) : (iter_q == 4'd7);
  assign lastKk     = dimIs4 || iter_q[0];
  assign releaseNow = running && tileEnd && lastKk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if (bus.en_data) begin
      mem_q[bus.addr] <= bus.data_in;
    end
  end

  // Lane r is skewed by r cycles: at counter c it carries element k = c - r of its row/column.
  for (genvar r = 0; r < 4; r++) begin : gLane
    logic [4:0] k;
    logic [5:0] a;
    assign k = tileCnt_q - 5'(r);
    assign a = bus.A_or_B ? (base + 6'(k[1:0]) * dimN + 6'(r))
                          : (base + 6'(r) * dimN + 6'(k[1:0]));
    assign lane_d[r] = (tileCnt_q >= 5'(r) && k <= 5'd3) ? mem_q[a] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tileCnt_q <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      for (int r = 0; r < 4; r++) lane_q[r] <= '0;
    end else if (bus.stop) begin
      tileCnt_q <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      for (int r = 0; r < 4; r++) lane_q[r] <= '0;
    end else begin
      clear_q <= releaseNow;
      for (int r = 0; r < 4; r++) lane_q[r] <= running ? lane_d[r] : '0;
      if (running) begin
        if (tileEnd) begin
          // The final tile leaves counter and iteration parked where they finished.
          if (lastIter) begin
            done_q <= 1'b1;
          end else begin
            tileCnt_q <= '0;
            iter_q    <= iter_q + 4'd1;
          end
        end else begin
          tileCnt_q <= tileCnt_q + 5'd1;
        end
      end
    end
  end

  assign bus.data_o_0                = lane_q[0];
  assign bus.data_o_1                = lane_q[1];
  assign bus.data_o_2                = lane_q[2];
  assign bus.data_o_3                = lane_q[3];
  assign bus.mem_done                = done_q;
  assign bus.release_output          = releaseNow;
  assign bus.clear                   = clear_q;
  assign bus.cnt                     = tileCnt_q;
  assign bus.current_iteration_debug = iter_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the operand buffer: a fixed vector table, hand-written corner
// sequences and a randomized phase, all checked against an integer-level reference model.
module tb_memory;

  logic clk = 1'b0;
  logic rst;
  memory_if bus ();

  memory dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int tickNo    = 0;

  logic signed [15:0] modelMem [64];
  int mCnt, mIt;
  bit mDone, mClear;
  int mOut [4];

  typedef struct {
    logic [4:0] instr;
    logic       aOrB;
    int         cyc;
    int         exp0, exp1, exp2, exp3;
  } vec_t;

  vec_t tbl [10];

  function automatic int dimOf(logic [4:0] instr);
    return (instr == 5'd4) ? 4 : 8;
  endfunction

  // Value a lane must carry for tile iteration it at counter c, straight from the tile geometry.
  function automatic int refLane(int r, int c, int it, int n, logic aOrB);
    int t, i, j, kk, k, base;
    t  = n / 4;
    i  = it / (t * t);
    j  = (it / t) % t;
    kk = it % t;
    k  = c - r;
    if (k < 0 || k > 3) return 0;
    if (!aOrB) begin
      base = 4 * i * n + 4 * kk;
      return int'(modelMem[base + r * n + k]);
    end
    base = 4 * kk * n + 4 * j;
    return int'(modelMem[base + k * n + r]);
  endfunction

  task automatic modelReset();
    for (int w = 0; w < 64; w++) modelMem[w] = '0;
    mCnt = 0; mIt = 0; mDone = 0; mClear = 0;
    for (int r = 0; r < 4; r++) mOut[r] = 0;
  endtask

  task automatic modelStep();
    int n, t;
    bit run, rel;
    n   = dimOf(bus.instruction);
    t   = n / 4;
    run = bus.start_compute && !bus.stop && !mDone;
    rel = run && mCnt == 11 && (mIt % t) == t - 1;
    if (bus.stop) begin
      mCnt = 0; mIt = 0; mDone = 0; mClear = 0;
      for (int r = 0; r < 4; r++) mOut[r] = 0;
    end else begin
      for (int r = 0; r < 4; r++) mOut[r] = run ? refLane(r, mCnt, mIt, n, bus.A_or_B) : 0;
      mClear = rel;
      if (run) begin
        if (mCnt == 11) begin
          if (mIt == t * t * t - 1) mDone = 1;
          else begin mCnt = 0; mIt++; end
        end else begin
          mCnt++;
        end
      end
    end
    if (bus.en_data) modelMem[bus.addr] = bus.data_in;
  endtask

  task automatic checkVal(string name, int got, int exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at tick %0d: got %0d, expected %0d", name, tickNo, got, exp);
    end
  endtask

  task automatic checkOutput();
    int n, t;
    bit expRel;
    n      = dimOf(bus.instruction);
    t      = n / 4;
    expRel = bus.start_compute && !bus.stop && !mDone && mCnt == 11 && (mIt % t) == t - 1;
    checkVal("data_o_0", int'(bus.data_o_0), mOut[0]);
    checkVal("data_o_1", int'(bus.data_o_1), mOut[1]);
    checkVal("data_o_2", int'(bus.data_o_2), mOut[2]);
    checkVal("data_o_3", int'(bus.data_o_3), mOut[3]);
    checkVal("mem_done", int'(bus.mem_done), int'(mDone));
    checkVal("release_output", int'(bus.release_output), int'(expRel));
    checkVal("clear", int'(bus.clear), int'(mClear));
    checkVal("cnt", int'(bus.cnt), mCnt);
    checkVal("iteration", int'(bus.current_iteration_debug), mIt);
  endtask

  task automatic applyStimulus(bit en, bit aOrB, bit start, bit stp,
                               logic [15:0] data, logic [5:0] a, logic [4:0] instr);
    bus.en_data       = en;
    bus.A_or_B        = aOrB;
    bus.start_compute = start;
    bus.stop          = stp;
    bus.data_in       = data;
    bus.addr          = a;
    bus.instruction   = instr;
  endtask

  task automatic tick();
    if (rst) modelReset();
    else modelStep();
    @(posedge clk);
    #1;
    tickNo++;
    checkOutput();
  endtask

  task automatic loadCounting();
    for (int k = 0; k < 64; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'(k + 1), 6'(k), 5'd4);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd0, 5'd4);
  endtask

  task automatic stopAndArm(bit aOrB, logic [4:0] instr);
    applyStimulus(1'b0, aOrB, 1'b0, 1'b1, 16'd0, 6'd0, instr);
    tick();
    applyStimulus(1'b0, aOrB, 1'b1, 1'b0, 16'd0, 6'd0, instr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int count, firstRel, maxIt, guard;

    tbl[0] = '{5'd4,  1'b0, 0,  1,  0,  0,  0};
    tbl[1] = '{5'd4,  1'b0, 2,  3,  6,  9,  0};
    tbl[2] = '{5'd4,  1'b0, 3,  4,  7, 10, 13};
    tbl[3] = '{5'd4,  1'b0, 6,  0,  0,  0, 16};
    tbl[4] = '{5'd8,  1'b1, 3, 25, 18, 11,  4};
    tbl[5] = '{5'd8,  1'b1, 12, 33, 0,  0,  0};
    tbl[6] = '{5'd16, 1'b1, 3, 25, 18, 11,  4};
    tbl[7] = '{5'd16, 1'b1, 12, 33, 0,  0,  0};
    tbl[8] = '{5'd8,  1'b0, 3,  4, 11, 18, 25};
    tbl[9] = '{5'd8,  1'b0, 15, 8, 15, 22, 29};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd0, 5'd4);
    modelReset();
    #12;
    checkOutput();
    rst = 1'b0;

    // Asynchronous reset in the middle of a run, then reload.
    loadCounting();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 6'd0, 5'd4);
    for (int s = 0; s < 5; s++) tick();
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd0, 5'd4);
    tick();
    rst = 1'b0;
    loadCounting();

    for (int v = 0; v < 10; v++) begin
      stopAndArm(tbl[v].aOrB, tbl[v].instr);
      for (int g = 0; g <= tbl[v].cyc; g++) tick();
      checkVal("vec lane0", int'(bus.data_o_0), tbl[v].exp0);
      checkVal("vec lane1", int'(bus.data_o_1), tbl[v].exp1);
      checkVal("vec lane2", int'(bus.data_o_2), tbl[v].exp2);
      checkVal("vec lane3", int'(bus.data_o_3), tbl[v].exp3);
    end

    // N=4 full run: done after 12 counting cycles with a trailing clear.
    stopAndArm(1'b0, 5'd4);
    count = 0;
    while (!bus.mem_done && count < 200) begin tick(); count++; end
    checkVal("N4 done cycles", count, 12);
    checkVal("N4 final clear", int'(bus.clear), 1);

    // N=8 B mode full run.
    stopAndArm(1'b1, 5'd8);
    count = 0; firstRel = -1; maxIt = 0;
    while (!bus.mem_done && count < 300) begin
      tick();
      count++;
      if (bus.release_output && firstRel < 0) firstRel = count;
      if (int'(bus.current_iteration_debug) > maxIt) maxIt = int'(bus.current_iteration_debug);
    end
    checkVal("N8 done cycles", count, 96);
    checkVal("N8 first release", firstRel, 23);
    checkVal("N8 max iteration", maxIt, 7);

    // Pause at counter 5 for three cycles.
    stopAndArm(1'b0, 5'd8);
    guard = 0;
    while (int'(bus.cnt) != 5 && guard < 50) begin tick(); guard++; end
    checkVal("pause reach", int'(bus.cnt), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd0, 5'd8);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkVal("pause cnt", int'(bus.cnt), 5);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 6'd0, 5'd8);
    tick();
    checkVal("resume cnt", int'(bus.cnt), 6);

    // Stop at iteration 3 with start still high, then restart in B mode.
    guard = 0;
    while (int'(bus.current_iteration_debug) != 3 && guard < 100) begin tick(); guard++; end
    checkVal("reach iter3", int'(bus.current_iteration_debug), 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 6'd0, 5'd8);
    tick();
    checkVal("stop cnt", int'(bus.cnt), 0);
    checkVal("stop iteration", int'(bus.current_iteration_debug), 0);
    checkVal("stop done", int'(bus.mem_done), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 6'd0, 5'd8);
    for (int s = 0; s < 4; s++) tick();
    checkVal("restart lane0", int'(bus.data_o_0), 25);
    checkVal("restart lane1", int'(bus.data_o_1), 18);
    checkVal("restart lane2", int'(bus.data_o_2), 11);
    checkVal("restart lane3", int'(bus.data_o_3), 4);

    // Randomized episodes: concurrent writes, pauses and occasional stops.
    for (int e = 0; e < 6; e++) begin
      logic [4:0] instr;
      bit aOrB;
      instr = (e % 3 == 0) ? 5'd4 : (e % 3 == 1) ? 5'd8 : 5'($urandom_range(0, 31));
      aOrB  = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, aOrB, 1'b0, 1'b1, 16'd0, 6'd0, instr);
      tick();
      for (int s = 0; s < 160; s++) begin
        applyStimulus($urandom_range(0, 3) == 0, aOrB, $urandom_range(0, 4) != 0,
                      $urandom_range(0, 49) == 0, 16'($urandom), 6'($urandom), instr);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
